// File: rtl/fifo_if.sv
// Handshake and status bundle between a FIFO and the logic that feeds and drains it.
// The master side issues write/read requests and data; the slave side (the FIFO)
// returns read data and the occupancy flags.
interface fifo_if #(
  parameter int WL = 8
);
  logic          write_rq;
  logic          read_rq;
  logic [WL-1:0] data_in;
  logic [WL-1:0] data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;

  modport master (
    output write_rq, read_rq, data_in,
    input  data_out, full, empty, almost_full, almost_empty
  );

  modport slave (
    input  write_rq, read_rq, data_in,
    output data_out, full, empty, almost_full, almost_empty
  );
endinterface

// File: rtl/fifo.sv
// Single-clock synchronous FIFO of DEPTH words, WL bits each.
// Reads are registered (one-cycle latency) and read-before-write when a read and
// a write hit the same slot, which can only happen while the FIFO is full.
// Status flags are exact-level decodes of the occupancy count.
module fifo #(
  parameter int WL    = 8,
  parameter int DEPTH = 8
) (
  input logic   clk,
  input logic   n_rst,
  fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   CNT_ZERO = '0;
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_AF   = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WL-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [WL-1:0] data_out_q;
  logic          wr_ok;
  logic          rd_ok;

  // A full FIFO still takes a write when a read frees a slot on the same edge;
  // an empty FIFO never services a read, even alongside a write.
  assign wr_ok = bus.write_rq & (~bus.full | bus.read_rq);
  assign rd_ok = bus.read_rq & ~bus.empty;

  assign bus.full         = (count == CNT_FULL);
  assign bus.empty        = (count == CNT_ZERO);
  assign bus.almost_full  = (count == CNT_AF);
  assign bus.almost_empty = (count == CNT_ONE);
  assign bus.data_out     = data_out_q;

  // Storage array: no reset, stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers, occupancy count and the registered read data.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out_q <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        data_out_q <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed testbench for the fifo block: reset, ordering, fill/overflow,
// pointer wrap, simultaneous read/write and underflow.
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_fifo;

  logic clk;
  logic n_rst;

  int tests_run;
  int tests_failed;

  fifo_if #(.WL(8)) bus ();

  fifo #(.WL(8), .DEPTH(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // Flag vector ordered {full, almost_full, almost_empty, empty}.
  logic [3:0] flags;
  assign flags = {bus.full, bus.almost_full, bus.almost_empty, bus.empty};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given requests, then requests drop again.
  task automatic drive_cycle(input logic w, input logic r, input logic [7:0] d);
    bus.write_rq = w;
    bus.read_rq  = r;
    bus.data_in  = d;
    @(posedge clk);
    #1;
    bus.write_rq = 1'b0;
    bus.read_rq  = 1'b0;
  endtask

  task automatic test_reset();
    n_rst        = 1'b1;
    bus.write_rq = 1'b1;
    bus.read_rq  = 1'b0;
    bus.data_in  = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (flags !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected %b", flags, 4'b0001);
    end
    tests_run++;
    if (bus.data_out !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_dout: got %h expected %h", bus.data_out, 8'h00);
    end
    n_rst        = 1'b0;
    bus.write_rq = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (flags !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_flags: got %b expected %b", flags, 4'b0001);
    end
    drive_cycle(1'b1, 1'b0, 8'h5A);
    tests_run++;
    if (flags !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL pre_async_flags: got %b expected %b", flags, 4'b0010);
    end
    drive_cycle(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h5A) begin
      tests_failed++;
      $display("[TB] FAIL pre_async_dout: got %h expected %h", bus.data_out, 8'h5A);
    end
    drive_cycle(1'b1, 1'b0, 8'h11);
    #3;
    n_rst = 1'b1;
    #1;
    tests_run++;
    if (flags !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL async_flags: got %b expected %b", flags, 4'b0001);
    end
    tests_run++;
    if (bus.data_out !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL async_dout: got %h expected %h", bus.data_out, 8'h00);
    end
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (flags !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL after_async_flags: got %b expected %b", flags, 4'b0001);
    end
  endtask

  task automatic test_basic_order();
    logic [3:0] exp_wflags [3] = '{4'b0010, 4'b0000, 4'b0000};
    logic [3:0] exp_rflags [3] = '{4'b0000, 4'b0010, 4'b0001};
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 8'(i));
      tests_run++;
      if (flags !== exp_wflags[i]) begin
        tests_failed++;
        $display("[TB] FAIL basic_wflags[%0d]: got %b expected %b", i, flags, exp_wflags[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (bus.data_out !== 8'(i)) begin
        tests_failed++;
        $display("[TB] FAIL basic_dout[%0d]: got %h expected %h", i, bus.data_out, 8'(i));
      end
      tests_run++;
      if (flags !== exp_rflags[i]) begin
        tests_failed++;
        $display("[TB] FAIL basic_rflags[%0d]: got %b expected %b", i, flags, exp_rflags[i]);
      end
    end
  endtask

  task automatic test_fill_overflow();
    logic [3:0] exp_f;
    for (int k = 1; k <= 8; k++) begin
      drive_cycle(1'b1, 1'b0, 8'(9 + k));
      exp_f = (k == 1) ? 4'b0010 : (k == 7) ? 4'b0100 : (k == 8) ? 4'b1000 : 4'b0000;
      tests_run++;
      if (flags !== exp_f) begin
        tests_failed++;
        $display("[TB] FAIL fill_flags[%0d]: got %b expected %b", k, flags, exp_f);
      end
    end
    drive_cycle(1'b1, 1'b0, 8'd99);
    tests_run++;
    if (flags !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL overflow_flags: got %b expected %b", flags, 4'b1000);
    end
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (bus.data_out !== 8'(10 + k)) begin
        tests_failed++;
        $display("[TB] FAIL drain_dout[%0d]: got %0d expected %0d", k, bus.data_out, 10 + k);
      end
    end
    tests_run++;
    if (flags !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL drain_flags: got %b expected %b", flags, 4'b0001);
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 5; k++) drive_cycle(1'b1, 1'b0, 8'(30 + k));
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (bus.data_out !== 8'(30 + k)) begin
        tests_failed++;
        $display("[TB] FAIL wrap_a_dout[%0d]: got %0d expected %0d", k, bus.data_out, 30 + k);
      end
    end
    for (int k = 0; k < 8; k++) drive_cycle(1'b1, 1'b0, 8'(20 + k));
    tests_run++;
    if (flags !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL wrap_full_flags: got %b expected %b", flags, 4'b1000);
    end
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (bus.data_out !== 8'(20 + k)) begin
        tests_failed++;
        $display("[TB] FAIL wrap_b_dout[%0d]: got %0d expected %0d", k, bus.data_out, 20 + k);
      end
    end
    tests_run++;
    if (flags !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL wrap_end_flags: got %b expected %b", flags, 4'b0001);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_mid [3] = '{8'd2, 8'd3, 8'd25};
    // Three stored, then read+write: count holds, oldest word comes out.
    for (int k = 1; k <= 3; k++) drive_cycle(1'b1, 1'b0, 8'(k));
    drive_cycle(1'b1, 1'b1, 8'd25);
    tests_run++;
    if (bus.data_out !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL sim3_dout: got %0d expected %0d", bus.data_out, 1);
    end
    tests_run++;
    if (flags !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL sim3_flags: got %b expected %b", flags, 4'b0000);
    end
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (bus.data_out !== exp_mid[k]) begin
        tests_failed++;
        $display("[TB] FAIL sim3_drain[%0d]: got %0d expected %0d", k, bus.data_out, exp_mid[k]);
      end
    end
    // Empty, read+write: only the write lands, data_out holds.
    drive_cycle(1'b1, 1'b1, 8'd3);
    tests_run++;
    if (flags !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL sim_empty_flags: got %b expected %b", flags, 4'b0010);
    end
    tests_run++;
    if (bus.data_out !== 8'd25) begin
      tests_failed++;
      $display("[TB] FAIL sim_empty_dout: got %0d expected %0d", bus.data_out, 25);
    end
    drive_cycle(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'd3) begin
      tests_failed++;
      $display("[TB] FAIL sim_empty_read: got %0d expected %0d", bus.data_out, 3);
    end
    // Full, read+write on the same slot: old word read, new word appended.
    for (int k = 0; k < 8; k++) drive_cycle(1'b1, 1'b0, 8'(40 + k));
    drive_cycle(1'b1, 1'b1, 8'd48);
    tests_run++;
    if (bus.data_out !== 8'd40) begin
      tests_failed++;
      $display("[TB] FAIL sim_full_dout: got %0d expected %0d", bus.data_out, 40);
    end
    tests_run++;
    if (flags !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL sim_full_flags: got %b expected %b", flags, 4'b1000);
    end
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (bus.data_out !== 8'(41 + k)) begin
        tests_failed++;
        $display("[TB] FAIL sim_full_drain[%0d]: got %0d expected %0d", k, bus.data_out, 41 + k);
      end
    end
  endtask

  task automatic test_underflow();
    drive_cycle(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'd48) begin
      tests_failed++;
      $display("[TB] FAIL underflow_dout: got %0d expected %0d", bus.data_out, 48);
    end
    tests_run++;
    if (flags !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL underflow_flags: got %b expected %b", flags, 4'b0001);
    end
    drive_cycle(1'b1, 1'b0, 8'h77);
    drive_cycle(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h77) begin
      tests_failed++;
      $display("[TB] FAIL underflow_recover: got %h expected %h", bus.data_out, 8'h77);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    n_rst        = 1'b1;
    bus.write_rq = 1'b0;
    bus.read_rq  = 1'b0;
    bus.data_in  = 8'h00;
    test_reset();
    test_basic_order();
    test_fill_overflow();
    test_wrap();
    test_simultaneous();
    test_underflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Single-clock synchronous FIFO buffer of DEPTH words, WL bits each.
- Producer pushes words with write_rq; consumer pops them with read_rq.
- Status flags full, almost_full, empty and almost_empty let upstream and downstream logic throttle.
- General-purpose datapath buffer between two blocks in the same clock domain.

Parameters:
- WL, 8, data word width in bits.
- DEPTH, 8, number of storage entries. Must be a power of two and at least 4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  reset, asynchronous, active-high. n_rst=1 clears the block immediately; normal operation while n_rst=0.
- write_rq  input  1  write request, sampled on rising clk.
- read_rq  input  1  read request, sampled on rising clk.
- data_in  input  WL  write data, captured when a write is accepted.
- full  output  1  1 when count == DEPTH.
- empty  output  1  1 when count == 0.
- almost_full  output  1  1 when count == DEPTH-1.
- almost_empty  output  1  1 when count == 1.
- data_out  output  WL  registered read data.

Behaviour:
State:
- Storage array mem[DEPTH].
- Write pointer wr_ptr, read pointer rd_ptr, each log2(DEPTH) bits.
- Occupancy count, log2(DEPTH)+1 bits.
- data_out register, WL bits.

Reset (n_rst=1, asynchronous, wins over everything):
- wr_ptr=0, rd_ptr=0, count=0, data_out=0.
- Flags: empty=1, full=0, almost_full=0, almost_empty=0.
- Memory contents need not be cleared.
- Asserting reset mid-operation discards all stored data.

Accept rules, evaluated per rising edge:
- wr_ok = write_rq & (~full | read_rq).
- rd_ok = read_rq & ~empty.
- Write when empty: accepted; a simultaneous read is ignored (rd_ok=0).
- Both requests when full: both accepted; count stays at DEPTH.
- Write when full with no read: ignored; no pointer, count or memory change.
- Read when empty: ignored; data_out holds its previous value.

Write (wr_ok):
- mem[wr_ptr] <= data_in.
- wr_ptr increments, wrapping modulo DEPTH.

Read (rd_ok):
- data_out <= mem[rd_ptr].
- rd_ptr increments, wrapping modulo DEPTH.
- Read latency: 1 clock. Data is valid on data_out right after the accepting edge.
- data_out holds its value on all non-read cycles.

Simultaneous read and write to the same address:
- The read returns the old stored word (read-before-write).
- This case only arises when full, so the read is always of valid data.

Count update:
- +1 on wr_ok only.
- -1 on rd_ok only.
- Unchanged when both or neither.

Flags:
- Combinational decodes of the count register, so they update in the same cycle as count.
- Flags are mutually consistent: full and empty are never both 1.
- almost_* are exact-level decodes, not thresholds: almost_full=0 when full=1.

Ordering: strict first-in first-out. Pointer wrap-around is invisible at the interface.

Test Plan:
- Reset: hold n_rst=1 for 2 cycles with write_rq=1 -> nothing stored; empty=1, data_out=0, other flags 0. Assert n_rst=1 asynchronously between clock edges -> flags reset immediately.
- Basic order: write 0,1,2, then read 3 times -> data_out 0,1,2, one cycle after each read edge. Flags across the sequence:
  - after first write: almost_empty=1;
  - after third read: empty=1.
- Fill/overflow: write 10..17 -> almost_full=1 at count 7, full=1 at count 8. Write 99 with no read -> ignored. Eight reads return 10..17 in order.
- Wrap-around: write 5 words, read 5, then write 8 and read 8 (values 20..27) -> correct order across pointer wrap; empty=1 at end.
- Simultaneous ops:
  - count=3, read+write of 25 -> count stays 3, data_out = oldest word, 25 emerges last;
  - empty, read+write of 3 -> count=1, data_out unchanged;
  - full, read+write -> count stays 8, oldest word output.
- Underflow: read on empty -> data_out holds last value, count stays 0, empty stays 1.
